// File: rtl/cpu_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_shift_pkg
// Description : Shared definitions for the multi-cycle shift/rotate unit:
//               default widths, operation codes and FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_shift_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    // Operation codes carried on the op bus
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Sequencer state codes
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/shift_seq_32_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_32_if
// Description : Request/response bundle of the multi-cycle shifter.
//               master : start, op, data_in, shamt -> ; <- busy, done, result
//               slave  : mirror image, used by the shifter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_32_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/shift_step_32.sv
`default_nettype none
// ============================================================================
// Module      : shift_step_32
// Description : Combinational one-bit left step of the shifter work register.
//               i_work : current work value
//               i_op   : operation code (selects the bit entering at bit 0)
//               i_fill : captured sign bit, used for SRA
//               o_work : work value shifted left by one
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step_32
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  wire logic [WIDTH-1:0] i_work,
    input  wire logic [1:0]       i_op,
    input  wire logic             i_fill,
    output logic      [WIDTH-1:0] o_work
);

    logic w_in_bit;

    // Right operations run on a bit-reversed operand, so the bit entering at
    // position 0 here ends up at the MSB once the result is reversed back.
    always_comb begin
        w_in_bit = 1'b0;
        case (i_op)
            SH_ROR:  w_in_bit = i_work[WIDTH-1];
            SH_SRA:  w_in_bit = i_fill;
            default: w_in_bit = 1'b0;
        endcase
    end

    assign o_work = {i_work[WIDTH-2:0], w_in_bit};

endmodule
`default_nettype wire

// File: rtl/shift_seq_32.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_32
// Description : Multi-cycle 32-bit shift/rotate unit, one bit per clock.
//               clk  : clock, rising edge
//               rst  : synchronous active-high reset
//               bus  : slave side of shift_seq_32_if
//                      start/op/data_in/shamt in, busy/done/result out
//               SLL uses the left datapath directly; SRL/SRA/ROR reverse the
//               operand on load and the result on unload.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_32
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  wire logic     clk,
    input  wire logic     rst,
    shift_seq_32_if.slave bus
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic               r_fill;
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH-1:0]   w_din_rev;
    logic [WIDTH-1:0]   w_work_rev;
    logic [WIDTH-1:0]   w_step;

    // Bit reversal is pure wiring.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign w_din_rev[gi]  = bus.data_in[WIDTH-1-gi];
        assign w_work_rev[gi] = r_work[WIDTH-1-gi];
    end

    shift_step_32 #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_work (r_work),
        .i_op   (r_op),
        .i_fill (r_fill),
        .o_work (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= SH_SLL;
            r_cnt    <= '0;
            r_work   <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op   <= bus.op;
                        r_cnt  <= bus.shamt;
                        r_work <= (bus.op == SH_SLL) ? bus.data_in : w_din_rev;
                        r_fill <= (bus.op == SH_SRA) ? bus.data_in[WIDTH-1] : 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt - SHAMT_W'(1);
                    end else begin
                        // Loaded on the edge entering DONE so the value is
                        // already present while done is high.
                        r_result <= (r_op == SH_SLL) ? r_work : w_work_rev;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)     w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0)   w_state_next = S_DONE;
            S_DONE:                     w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    assign bus.busy   = (r_state == S_SHIFT);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq_32
// Description : Self-checking bench for shift_seq_32. Directed scenarios plus
//               random operations compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_32;

    localparam int         C_LIMIT = 80;
    localparam logic [1:0] C_SLL   = 2'b00;
    localparam logic [1:0] C_SRL   = 2'b01;
    localparam logic [1:0] C_SRA   = 2'b10;
    localparam logic [1:0] C_ROR   = 2'b11;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    shift_seq_32_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_seq_32 #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic shifts and a rotate from a doubled word.
    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [63:0] dd;
        dd = {d, d} >> sh;
        case (op)
            C_SLL:   return d << sh;
            C_SRL:   return d >> sh;
            C_SRA:   return 32'($signed(d) >>> sh);
            default: return dd[31:0];
        endcase
    endfunction

    // Issues one request and observes the response. lat is the cycle number
    // (relative to the accepting edge) in which done first rose, -1 if never.
    task automatic run_op(input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input bit inject,
                          input logic [31:0] inj_d,
                          output int lat, output int dones,
                          output int busy_cyc, output logic [31:0] res);
        @(negedge clk);
        bus.op = op; bus.data_in = d; bus.shamt = sh; bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = $urandom;
        bus.op      = 2'($urandom);
        bus.shamt   = 5'($urandom);
        lat = -1; dones = 0; busy_cyc = 0; res = '0;
        for (int k = 1; k <= C_LIMIT; k++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    res = bus.result;
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
            if (inject && k == 2) begin
                bus.start = 1'b1; bus.data_in = inj_d; bus.op = C_SLL; bus.shamt = 5'd3;
            end else if (inject && k == 3) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.op = C_SLL; bus.data_in = '0; bus.shamt = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        n_checks++;
        if (bus.result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h want 00000000", bus.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed(input string name, input logic [1:0] op,
                                 input logic [31:0] d, input logic [4:0] sh,
                                 input logic [31:0] exp_res);
        int lat, dones, busy_cyc;
        logic [31:0] res;
        run_op(op, d, sh, 1'b0, 32'h0, lat, dones, busy_cyc, res);
        n_checks++;
        if (res !== exp_res) begin
            n_fail++; $display("FAIL %s_result: got %h want %h", name, res, exp_res);
        end
        n_checks++;
        if (lat !== int'(sh) + 2) begin
            n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, int'(sh) + 2);
        end
        n_checks++;
        if (busy_cyc !== int'(sh) + 1) begin
            n_fail++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cyc, int'(sh) + 1);
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", name, dones);
        end
        n_checks++;
        if (bus.result !== exp_res) begin
            n_fail++; $display("FAIL %s_result_held: got %h want %h", name, bus.result, exp_res);
        end
    endtask

    task automatic test_ignored_start();
        int lat, dones, busy_cyc;
        logic [31:0] res;
        run_op(C_SLL, 32'h1, 5'd8, 1'b1, 32'hFFFF_FFFF, lat, dones, busy_cyc, res);
        n_checks++;
        if (res !== 32'h0000_0100) begin
            n_fail++; $display("FAIL ignored_start_result: got %h want 00000100", res);
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++; $display("FAIL ignored_start_done_pulses: got %0d want 1", dones);
        end
        n_checks++;
        if (lat !== 10) begin
            n_fail++; $display("FAIL ignored_start_latency: got %0d want 10", lat);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.op = C_SLL; bus.data_in = 32'h0000_0003; bus.shamt = 5'd20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_done: got %b want 0", bus.done);
        end
        n_checks++;
        if (bus.result !== 32'h0) begin
            n_fail++; $display("FAIL midreset_result: got %h want 00000000", bus.result);
        end
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL midreset_stray_done: got %0d want 0", dones);
        end
        test_directed("post_reset_sra", C_SRA, 32'h8000_00F0, 5'd4, 32'hF800_000F);
    endtask

    task automatic test_random();
        int lat, dones, busy_cyc;
        logic [31:0] res, d, exp_res;
        logic [1:0]  op;
        logic [4:0]  sh;
        for (int i = 0; i < 24; i++) begin
            d  = $urandom;
            op = 2'($urandom);
            sh = 5'($urandom);
            exp_res = ref_shift(op, d, sh);
            run_op(op, d, sh, 1'b0, 32'h0, lat, dones, busy_cyc, res);
            n_checks++;
            if (res !== exp_res || lat !== int'(sh) + 2 || dones !== 1) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d d=%h sh=%0d: got res=%h lat=%0d dones=%0d want res=%h lat=%0d dones=1",
                         i, op, d, sh, res, lat, dones, exp_res, int'(sh) + 2);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed("sll", C_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
        test_directed("sra", C_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000);
        test_directed("srl", C_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000);
        test_directed("ror", C_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000);
        test_directed("srl_zero", C_SRL, 32'h1234_5678, 5'd0, 32'h1234_5678);
        test_directed("ror_wrap", C_ROR, 32'h0000_00F1, 5'd4, 32'h1000_000F);
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
